// File: rtl/fft_bin_mag_if.sv
// Bus between the FFT output stage and the bin-magnitude block.
// Peak-report signals exist only when FFT_PEAK_EN is defined.
interface fft_bin_mag_if;
  logic               finish_i;
  logic signed [16:0] answer_i;
  logic               mag_valid_o;
  logic        [16:0] mag_o;
  logic        [4:0]  bin_o;
  logic               frame_done_o;
`ifdef FFT_PEAK_EN
  logic        [4:0]  peak_bin_o;
  logic        [16:0] peak_mag_o;
`endif

  modport master (
    output finish_i, answer_i,
    input  mag_valid_o, mag_o, bin_o, frame_done_o
`ifdef FFT_PEAK_EN
    , input peak_bin_o, peak_mag_o
`endif
  );

  modport slave (
    input  finish_i, answer_i,
    output mag_valid_o, mag_o, bin_o, frame_done_o
`ifdef FFT_PEAK_EN
    , output peak_bin_o, peak_mag_o
`endif
  );
endinterface

// File: rtl/fft_bin_mag.sv
// Per-bin magnitude estimate (max + min/2) from a 64-word real/imag FFT frame.
// Optional frame peak tracker enabled by defining FFT_PEAK_EN.
module fft_bin_mag (
  input  logic          clk,
  input  logic          rst_n,
  fft_bin_mag_if.slave  bus
);
  typedef enum logic {S_REAL = 1'b0, S_IMAG = 1'b1} state_t;

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic               accept_re, accept_im;
  logic signed [16:0] re_buf [32];
  logic [16:0]        abs_re, abs_im, mag_big, mag_small, mag_calc;

  // Unsigned 17-bit result so the most negative input maps to 65536.
  function automatic logic [16:0] abs17(input logic signed [16:0] x);
    return x[16] ? (~x + 17'd1) : x;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept_re  = 1'b0;
    accept_im  = 1'b0;
    case (state)
      S_REAL: if (bus.finish_i) begin
        accept_re = 1'b1;
        if (cnt == 6'd31) state_next = S_IMAG;
      end
      S_IMAG: if (bus.finish_i) begin
        accept_im = 1'b1;
        if (cnt == 6'd63) state_next = S_REAL;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REAL;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      if (bus.finish_i) cnt <= cnt + 6'd1;
    end
  end

  // NOTE: the real buffer is plain storage with no reset; it is always written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (accept_re) re_buf[cnt[4:0]] <= bus.answer_i;
  end

  always_comb begin
    abs_re = abs17(re_buf[cnt[4:0]]);
    abs_im = abs17(bus.answer_i);
    if (abs_re >= abs_im) begin
      mag_big   = abs_re;
      mag_small = abs_im;
    end else begin
      mag_big   = abs_im;
      mag_small = abs_re;
    end
    // Worst case 65536 + 32768 = 98304, which fits in 17 bits.
    mag_calc = mag_big + (mag_small >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mag_valid_o  <= 1'b0;
      bus.mag_o        <= 17'd0;
      bus.bin_o        <= 5'd0;
      bus.frame_done_o <= 1'b0;
    end else begin
      bus.mag_valid_o  <= accept_im;
      bus.frame_done_o <= accept_im && (cnt == 6'd63);
      if (accept_im) begin
        bus.mag_o <= mag_calc;
        bus.bin_o <= cnt[4:0];
      end
    end
  end

`ifdef FFT_PEAK_EN
  logic [16:0] run_mag;
  logic [4:0]  run_bin;

  // Bin 31 is compared directly against the running max so it lands in the same report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mag        <= 17'd0;
      run_bin        <= 5'd0;
      bus.peak_mag_o <= 17'd0;
      bus.peak_bin_o <= 5'd0;
    end else begin
      if (accept_re && cnt == 6'd0) begin
        run_mag <= 17'd0;
        run_bin <= 5'd0;
      end else if (accept_im && mag_calc > run_mag) begin
        run_mag <= mag_calc;
        run_bin <= cnt[4:0];
      end
      if (accept_im && cnt == 6'd63) begin
        if (mag_calc > run_mag) begin
          bus.peak_mag_o <= mag_calc;
          bus.peak_bin_o <= 5'd31;
        end else begin
          bus.peak_mag_o <= run_mag;
          bus.peak_bin_o <= run_bin;
        end
      end
    end
  end
`endif
endmodule
